mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer sharing one unified memory port between the CPU's instruction-fetch path and its load/store path. Each requester uses a req/ready handshake. The arbiter grants one owner at a time with round-robin tie-breaking and drives a req/ack memory interface. It also enforces a timeout on the memory side and routes the read data and an error flag back to the owner. It sits between the PC/fetch logic and ALU-driven data access on one side and a single multi-cycle memory on the other.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte-enable width is `DATA_W/8`.
- `TIMEOUT`, default 16: cycles `mem_req` may stay high without `mem_ack` before abort; legal range 2..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held with a stable `if_addr` until `if_ready`.
- `if_addr` in ADDR_W: fetch address.
- `if_ready` out 1: one-cycle pulse; fetch complete.
- `if_rdata` out DATA_W: fetched word; valid while `if_ready`.
- `d_req` in 1: data request; `d_we`/`d_addr`/`d_wdata`/`d_be` held stable until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_be` in DATA_W/8: store byte enables.
- `d_ready` out 1: one-cycle pulse; data access complete.
- `d_rdata` out DATA_W: load data; valid while `d_ready`.
- `err` out 1: valid with either ready pulse; 1 = timed out.
- `mem_req` out 1: memory request, held until ack or timeout.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` out: registered copies of the granted request; fetch forces we=0, be=all ones, wdata=0.
- `mem_ack` in 1: memory completion, sampled only while `mem_req`=1.
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE → BUSY when any req is high.
  - Grant rule: data only → data; fetch only → fetch; both → whichever is not `last_grant`.
  - `last_grant` resets to FETCH, so the first tie goes to data.
  - On the grant edge: latch owner and request fields into the `mem_*` registers, update `last_grant`, clear the timeout counter.
- BUSY: `mem_req`=1; the counter increments each cycle without `mem_ack`.
  - `mem_ack`=1 → capture `mem_rdata`, set err=0, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack → set rdata=0, err=1, go to RESP.
  - An ack in the final timeout cycle wins (err=0).
- RESP: the owner's ready=1 for exactly one cycle; `mem_req`=0; no requests are sampled; next state is IDLE.
- Requests arriving during BUSY or RESP wait; the requester keeps req high.
- The non-owner's ready stays 0 throughout. Its rdata output holds its last value.
- Stores return `d_rdata` = `mem_rdata` as acked. Consumers ignore it.

## Timing
- Reset values: state IDLE; all ready, err, and `mem_req` = 0; all data/address outputs = 0; `last_grant` = FETCH.
- Reset mid-transaction: `mem_req` drops asynchronously. The in-flight access is abandoned and no ready is issued.
- Req sampled high at edge N → `mem_req` high from cycle N+1.
- Ack in cycle N+1 → ready in cycle N+2 → IDLE in cycle N+3. Minimum 3-cycle turnaround per access.
- A requester may present its next request in the cycle after ready. That request is sampled in IDLE.
- Both requests continuously high → grants alternate D, F, D, F…; neither starves.
- Timeout with no ack ever: `mem_req` high for exactly TIMEOUT cycles, then a ready pulse with err=1.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, BUSY, RESP}
  - `owner_t` enum {OWN_FETCH, OWN_DATA}
  - default width localparams
- Single module; no sub-module needed. The timeout counter is inline, `$clog2(TIMEOUT)` bits wide.

## Test plan
- Fetch only, addr 0x0000_0010, ack after 2 cycles with 0x0050_0093 → `mem_req` high 2 cycles, `mem_we`=0, `mem_be`=0xF, `if_ready` pulse with `if_rdata`=0x0050_0093, err=0.
- Both reqs in the same cycle after reset, zero-wait ack → data granted first, then fetch; exactly 3 cycles between the two ready pulses.
- Both held high for 6 grants → grant order D, F, D, F, D, F.
- Store `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF, `d_be`=0x3 → `mem_*` fields match exactly; `d_ready` pulse; `if_ready` stays 0.
- No ack, TIMEOUT=4 → `mem_req` high exactly 4 cycles, then `d_ready`=1, err=1, `d_rdata`=0; the next request proceeds normally.
- `rst` asserted mid-BUSY → `mem_req`=0 in the same cycle, no ready pulse, FSM in IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int ARB_ADDR_W  = 32;
  localparam int ARB_DATA_W  = 32;
  localparam int ARB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one req/ack memory port between fetch and load/store,
// with a memory-side timeout and per-owner response routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_r;
  state_t           state_s;
  owner_t           owner_r;
  owner_t           last_grant_r;
  owner_t           grant_s;
  logic [CNT_W-1:0] cnt_r;
  logic             start_s;
  logic             done_s;
  logic             timeout_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, grant choice and completion decode
  always_comb begin
    state_s   = state_r;
    grant_s   = last_grant_r;
    start_s   = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req || d_req) begin
          start_s = 1'b1;
          state_s = BUSY;
          if (d_req && !if_req) begin
            grant_s = OWN_DATA;
          end else if (if_req && !d_req) begin
            grant_s = OWN_FETCH;
          end else if (last_grant_r == OWN_FETCH) begin
            grant_s = OWN_DATA;
          end else begin
            grant_s = OWN_FETCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // An ack landing in the last allowed cycle still completes cleanly.
        if (mem_ack) begin
          done_s  = 1'b1;
          state_s = RESP;
        end else if (cnt_r == CNT_LAST) begin
          done_s    = 1'b1;
          timeout_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = BUSY;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request latch, timeout counter and response routing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r      <= OWN_FETCH;
      last_grant_r <= OWN_FETCH;
      cnt_r        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      if_ready     <= 1'b0;
      d_ready      <= 1'b0;
      err          <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      if (start_s) begin
        owner_r      <= grant_s;
        last_grant_r <= grant_s;
        cnt_r        <= '0;
        mem_req      <= 1'b1;
        if (grant_s == OWN_DATA) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_be    <= d_be;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_be    <= {BE_W{1'b1}};
        end
      end else if (done_s) begin
        mem_req <= 1'b0;
        err     <= timeout_s;
        if (owner_r == OWN_DATA) begin
          d_ready <= 1'b1;
          d_rdata <= timeout_s ? '0 : mem_rdata;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= timeout_s ? '0 : mem_rdata;
        end
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // memory model controls: ack in the ack_at-th cycle of mem_req (0 = never)
  int          ack_at = 1;
  logic [31:0] rd_val = 32'h0;
  int          model_cnt = 0;

  // per-transaction observations
  int          mreq_cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        saw_if_ready;
  logic        saw_d_ready;
  int          c1;
  int          c2;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        model_cnt++;
        if (model_cnt == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_val;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'h0;
        end
      end else begin
        model_cnt = 0;
        mem_ack   = 1'b0;
      end
    end
  end

  task automatic wait_ready(input string tag);
    bit got = 1'b0;
    mreq_cnt     = 0;
    saw_if_ready = 1'b0;
    saw_d_ready  = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (mem_req) begin
        if (mreq_cnt == 0) begin
          cap_we    = mem_we;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
          cap_be    = mem_be;
        end
        mreq_cnt++;
      end
      if (if_ready) saw_if_ready = 1'b1;
      if (d_ready)  saw_d_ready  = 1'b1;
      if (if_ready || d_ready) got = 1'b1;
    end
    if (!got) check({tag, "_bound"}, 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_mem_req",  64'(mem_req),  64'(0));
    check("rst_if_ready", 64'(if_ready), 64'(0));
    check("rst_d_ready",  64'(d_ready),  64'(0));
    check("rst_err",      64'(err),      64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_if_rdata", 64'(if_rdata), 64'(0));
    rst = 1'b0;

    // fetch only, ack in second cycle
    ack_at = 2; rd_val = 32'h0050_0093;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0010;
    wait_ready("f1");
    if_req = 1'b0;
    check("f1_mreq_cycles", 64'(mreq_cnt), 64'(2));
    check("f1_mem_we",      64'(cap_we),   64'(0));
    check("f1_mem_be",      64'(cap_be),   64'(4'hF));
    check("f1_mem_addr",    64'(cap_addr), 64'(32'h10));
    check("f1_if_ready",    64'(if_ready), 64'(1));
    check("f1_if_rdata",    64'(if_rdata), 64'(32'h0050_0093));
    check("f1_err",         64'(err),      64'(0));
    @(negedge clk);
    check("f1_pulse_1cyc",  64'(if_ready), 64'(0));

    // simultaneous requests after reset: data wins first tie
    do_reset();
    ack_at = 1; rd_val = 32'h1111_2222;
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    wait_ready("tie1");
    c1 = cyc;
    check("tie1_d_ready",  64'(d_ready),  64'(1));
    check("tie1_if_ready", 64'(if_ready), 64'(0));
    d_req = 1'b0;
    wait_ready("tie2");
    c2 = cyc;
    if_req = 1'b0;
    check("tie2_if_ready", 64'(if_ready), 64'(1));
    check("tie_spacing",   64'(c2 - c1),  64'(3));

    // both held: D,F,D,F,D,F
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      wait_ready("rr");
      check($sformatf("rr_grant%0d_d", g), 64'(d_ready), 64'((g % 2) == 0));
      check($sformatf("rr_grant%0d_addr", g), 64'(cap_addr),
            64'(((g % 2) == 0) ? 32'h2000 : 32'h1000));
    end
    if_req = 1'b0; d_req = 1'b0;

    // store field pass-through
    @(negedge clk);
    ack_at = 1; rd_val = 32'h1234_5678;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    wait_ready("st");
    d_req = 1'b0;
    check("st_mem_we",    64'(cap_we),       64'(1));
    check("st_mem_addr",  64'(cap_addr),     64'(32'h100));
    check("st_mem_wdata", 64'(cap_wdata),    64'(32'hDEAD_BEEF));
    check("st_mem_be",    64'(cap_be),       64'(4'h3));
    check("st_d_ready",   64'(d_ready),      64'(1));
    check("st_no_if_rdy", 64'(saw_if_ready), 64'(0));
    check("st_d_rdata",   64'(d_rdata),      64'(32'h1234_5678));

    // timeout with no ack
    @(negedge clk);
    ack_at = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    wait_ready("to");
    d_req = 1'b0;
    check("to_mreq_cycles", 64'(mreq_cnt), 64'(4));
    check("to_d_ready",     64'(d_ready),  64'(1));
    check("to_err",         64'(err),      64'(1));
    check("to_d_rdata",     64'(d_rdata),  64'(0));

    // next request proceeds normally; d_rdata holds
    @(negedge clk);
    ack_at = 1; rd_val = 32'hCAFE_0001;
    if_req = 1'b1; if_addr = 32'h44;
    wait_ready("after_to");
    if_req = 1'b0;
    check("ato_if_ready", 64'(if_ready), 64'(1));
    check("ato_if_rdata", 64'(if_rdata), 64'(32'hCAFE_0001));
    check("ato_err",      64'(err),      64'(0));
    check("ato_d_hold",   64'(d_rdata),  64'(0));

    // ack in the final timeout cycle wins
    @(negedge clk);
    ack_at = 4; rd_val = 32'hABCD_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    wait_ready("late");
    d_req = 1'b0;
    check("late_mreq_cycles", 64'(mreq_cnt), 64'(4));
    check("late_err",         64'(err),      64'(0));
    check("late_d_rdata",     64'(d_rdata),  64'(32'hABCD_0004));

    // reset mid-BUSY
    @(negedge clk);
    ack_at = 0;
    d_req = 1'b1; d_addr = 32'h400;
    repeat (2) @(negedge clk);
    check("mid_busy_req", 64'(mem_req), 64'(1));
    rst = 1'b1;
    #1;
    check("rst_async_req", 64'(mem_req), 64'(0));
    @(negedge clk);
    d_req = 1'b0;
    rst = 1'b0;
    saw_if_ready = 1'b0; saw_d_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if_ready || d_ready || mem_req) saw_d_ready = 1'b1;
    end
    check("rst_no_ready", 64'(saw_d_ready), 64'(0));
    ack_at = 1; rd_val = 32'h5555_AAAA;
    if_req = 1'b1; if_addr = 32'h80;
    wait_ready("post_rst");
    if_req = 1'b0;
    check("post_rst_cycles", 64'(mreq_cnt), 64'(1));
    check("post_rst_rdata",  64'(if_rdata), 64'(32'h5555_AAAA));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
